// File: rtl/rr_grant_arbiter4_if.sv
// Request/grant bundle between the requesting blocks and rr_grant_arbiter4.
//   req     [3:0]  request vector, bit i = requester i (level)
//   rel            release strobe from the current grantee
//   gnt     [3:0]  one-hot grant, zero when not busy
//   gnt_id  [1:0]  current or last grantee index
//   busy           high while a grant is held
//   timeout        one-cycle pulse on a forced release
// master: requester side; slave: arbiter side.
interface rr_grant_arbiter4_if;
  logic [3:0] req;
  logic       rel;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req, rel,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, rel,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/rr_grant_arbiter4.sv
// 4-requester round-robin arbiter for one shared resource. One grantee at a
// time; the grant is held until REL or until the grantee drops its request.
// The priority pointer moves to the slot after the last grantee on release.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rr_grant_arbiter4_if.slave (req, rel in; gnt, gnt_id, busy, timeout out)
// Parameter:
//   TIMEOUT_CYCLES  max grant length before forced release (2..256)
// Optional feature macro: ARB_TIMEOUT_EN (grant timeout). Without it no
// counter is built and timeout is tied low.
module rr_grant_arbiter4 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_grant_arbiter4_if.slave   bus
);

  // Reject out-of-range configuration at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("rr_grant_arbiter4: TIMEOUT_CYCLES must be in 2..256");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Rotate requests so the pointer slot sits at bit 0, then take the first set bit.
  logic [7:0] req_dbl_c;
  logic [3:0] req_rot_c;
  logic [1:0] offset_c;
  logic [1:0] winner_c;
  logic       release_c;

  always_comb begin
    req_dbl_c = {bus.req, bus.req};
    req_rot_c = 4'(req_dbl_c >> ptr_q);
    offset_c  = 2'd0;
    casez (req_rot_c)
      4'b???1: offset_c = 2'd0;
      4'b??10: offset_c = 2'd1;
      4'b?100: offset_c = 2'd2;
      4'b1000: offset_c = 2'd3;
      default: offset_c = 2'd0;
    endcase
    winner_c  = ptr_q + offset_c;
    // REL and a dropped request in the same cycle are one release.
    release_c = bus.rel || !bus.req[gnt_id_q];
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d  = ST_GRANT;
          gnt_id_d = winner_c;
          gnt_d    = 4'b0001 << winner_c;
          busy_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = gnt_id_q + 2'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          ptr_d     = gnt_id_q + 2'd1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any grant at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      gnt_id_q <= 2'd0;
      gnt_q    <= 4'b0000;
      busy_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Self-checking bench for rr_grant_arbiter4: directed scenarios followed by
// random traffic, all checked against a behavioural round-robin model.
module tb_rr_grant_arbiter4;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TC = 4;

  logic clk;
  logic rst;
  rr_grant_arbiter4_if arb_if ();

  rr_grant_arbiter4 #(.TIMEOUT_CYCLES(TC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int m_busy = 0;
  int m_id   = 0;
  int m_ptr  = 0;
  int m_age  = 0;
  int m_to   = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, check every output after the edge.
  task automatic cycle(input logic [3:0] r, input logic l, input logic rs);
    int nb, nid, nptr, nage, nto, idx;
    bit found;
    logic [3:0] exp_gnt;
    arb_if.req = r;
    arb_if.rel = l;
    rst        = rs;
    nb = m_busy; nid = m_id; nptr = m_ptr; nage = m_age; nto = 0;
    if (rs) begin
      nb = 0; nid = 0; nptr = 0; nage = 0;
    end else if (m_busy == 0) begin
      if (r != 4'b0000) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (!found && r[idx]) begin
            found = 1'b1;
            nid   = idx;
          end
        end
        nb = 1; nage = 0;
      end
    end else if (l || !r[m_id]) begin
      nb = 0; nptr = (m_id + 1) % 4;
    end else if (TO_EN && m_age == TC - 1) begin
      nb = 0; nptr = (m_id + 1) % 4; nto = 1;
    end else begin
      nage = m_age + 1;
    end
    @(posedge clk);
    #1;
    m_busy = nb; m_id = nid; m_ptr = nptr; m_age = nage; m_to = nto;
    exp_gnt = (m_busy != 0) ? 4'(1 << m_id) : 4'b0000;
    chk("model_gnt", arb_if.gnt, exp_gnt);
    chk("model_gnt_id", {2'b00, arb_if.gnt_id}, 4'(m_id));
    chk("model_busy", {3'b000, arb_if.busy}, 4'(m_busy));
    chk("model_timeout", {3'b000, arb_if.timeout}, 4'(m_to));
  endtask

  initial begin
    arb_if.req = 4'b0000;
    arb_if.rel = 1'b0;
    rst        = 1'b1;

    // Reset state.
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b1111, 1'b1, 1'b1);
    chk("rst_gnt", arb_if.gnt, 4'b0000);
    chk("rst_busy", {3'b000, arb_if.busy}, 4'b0000);

    // 1: single requester, grant then REL release.
    cycle(4'b0001, 1'b0, 1'b0);
    chk("t1_gnt", arb_if.gnt, 4'b0001);
    chk("t1_busy", {3'b000, arb_if.busy}, 4'b0001);
    cycle(4'b0001, 1'b1, 1'b0);
    chk("t1_rel_gnt", arb_if.gnt, 4'b0000);

    // 2: all requesting, REL once per grant -> 1,2,3,0 after the grant to 0 above.
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    chk("t2_id1", {2'b00, arb_if.gnt_id}, 4'd1);
    for (int g = 0; g < 4; g++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      chk("t2_gap", {3'b000, arb_if.busy}, 4'b0000);
      cycle(4'b1111, 1'b0, 1'b0);
      chk("t2_seq", {2'b00, arb_if.gnt_id}, 4'((2 + g) % 4));
    end
    cycle(4'b0000, 1'b1, 1'b0);

    // 3: wrap after requester 2.
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0);
    cycle(4'b0101, 1'b0, 1'b0);
    chk("t3_wrap", arb_if.gnt, 4'b0001);
    cycle(4'b0101, 1'b1, 1'b0);
    cycle(4'b0101, 1'b0, 1'b0);
    chk("t3_next", arb_if.gnt, 4'b0100);
    cycle(4'b0000, 1'b1, 1'b0);

    // 4: grantee drops request; then REL and drop together.
    cycle(4'b0010, 1'b0, 1'b0);
    chk("t4_gnt1", arb_if.gnt, 4'b0010);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("t4_drop", arb_if.gnt, 4'b0000);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("t4_idle", {3'b000, arb_if.busy}, 4'b0000);
    cycle(4'b1111, 1'b0, 1'b0);
    chk("t4_ptr2", arb_if.gnt, 4'b0100);
    cycle(4'b0000, 1'b1, 1'b0);

    // 5: held request with no REL.
    cycle(4'b0000, 1'b0, 1'b1);
    if (TO_EN) begin
      for (int c = 0; c < TC; c++) begin
        cycle(4'b0010, 1'b0, 1'b0);
        chk("t5_held", arb_if.gnt, 4'b0010);
      end
      cycle(4'b0010, 1'b0, 1'b0);
      chk("t5_to", {3'b000, arb_if.timeout}, 4'b0001);
      chk("t5_to_gnt", arb_if.gnt, 4'b0000);
      cycle(4'b0010, 1'b0, 1'b0);
      chk("t5_regrant", arb_if.gnt, 4'b0010);
    end else begin
      for (int c = 0; c < 100; c++) begin
        cycle(4'b0010, 1'b0, 1'b0);
        chk("t5_held", arb_if.gnt, 4'b0010);
      end
    end

    // 6: reset mid-grant.
    cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b1);
    chk("t6_gnt", arb_if.gnt, 4'b0000);
    chk("t6_id", {2'b00, arb_if.gnt_id}, 4'b0000);
    cycle(4'b1111, 1'b0, 1'b0);
    chk("t6_first", arb_if.gnt, 4'b0001);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
